// File: rtl/tb_cigar_rle_if.sv
// ============================================================================
// Module      : tb_cigar_rle_if
// Description : Bundle for the CIGAR run-length encoder. It carries the
//               traceback pointer stream coming in from the aligner and the
//               op stream going out to a host or DMA engine.
//               Modport master : environment side (aligner + consumer).
//               Modport slave  : encoder side.
//               Optional macro TB_CIGAR_COUNT_EN adds the per-type counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tb_cigar_rle_if #(
   parameter int RUN_WIDTH = 16
);
   logic [1:0]           tb_pointer;  // 1=M, 2=I, 3=D, 0=no-op
   logic                 tb_valid;
   logic                 stop;        // tile done, level
   logic                 last_tile;   // qualifies the stop rising edge
   logic                 op_valid;
   logic                 op_ready;
   logic [1:0]           op_code;
   logic [RUN_WIDTH-1:0] op_len;
   logic                 op_last;
   logic                 overflow;
   logic                 busy;
`ifdef TB_CIGAR_COUNT_EN
   logic [31:0]          m_total;
   logic [31:0]          i_total;
   logic [31:0]          d_total;
`endif

   modport master (
      output tb_pointer, tb_valid, stop, last_tile, op_ready,
      input  op_valid, op_code, op_len, op_last, overflow, busy
`ifdef TB_CIGAR_COUNT_EN
      , input m_total, i_total, d_total
`endif
   );

   modport slave (
      input  tb_pointer, tb_valid, stop, last_tile, op_ready,
      output op_valid, op_code, op_len, op_last, overflow, busy
`ifdef TB_CIGAR_COUNT_EN
      , output m_total, i_total, d_total
`endif
   );
endinterface

`default_nettype wire

// File: rtl/tb_cigar_rle.sv
// ============================================================================
// Module      : tb_cigar_rle
// Description : Collapses the aligner traceback pointer stream into
//               run-length CIGAR ops, keeps runs open across tile
//               boundaries, and queues ops in a FIFO drained with
//               valid/ready. The final run is flushed on the stop edge of
//               the last tile.
// Ports       : clk  - core clock
//               rst  - asynchronous active-low reset
//               cif  - tb_cigar_rle_if.slave
//                      in : tb_pointer, tb_valid, stop, last_tile, op_ready
//                      out: op_valid, op_code, op_len, op_last, overflow, busy
//                      out: m_total, i_total, d_total (TB_CIGAR_COUNT_EN only)
// Options     : TB_CIGAR_COUNT_EN - per-type accepted pointer counters
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cigar_rle #(
   parameter int RUN_WIDTH      = 16,
   parameter int FIFO_DEPTH     = 16,
   parameter int LOG_FIFO_DEPTH = 4
) (
   input  wire logic        clk,
   input  wire logic        rst,
   tb_cigar_rle_if.slave    cif
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_RUN   = 2'd1;
   localparam logic [1:0] c_FLUSH = 2'd2;
   localparam logic [1:0] c_DRAIN = 2'd3;

   localparam int                   c_ENT_W   = RUN_WIDTH + 3;  // {last, code, len}
   localparam int                   c_PTR_W   = LOG_FIFO_DEPTH + 1;
   localparam logic [RUN_WIDTH-1:0] c_LEN_MAX = {RUN_WIDTH{1'b1}};

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [1:0]           state_q, state_d;
   logic                 stop_q;
   logic                 run_valid_q, run_valid_d;
   logic [1:0]           cur_op_q, cur_op_d;
   logic [RUN_WIDTH-1:0] len_q, len_d;
   logic [c_PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic                 overflow_q;
   logic [c_ENT_W-1:0]   mem_q [FIFO_DEPTH];

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic                 w_final_edge;
   logic                 w_ptr_ok;
   logic                 w_extend;
   logic                 w_empty;
   logic                 w_full;
   logic                 w_pop;
   logic                 w_push_req;
   logic                 w_push;
   logic [c_ENT_W-1:0]   w_push_data;
   logic [c_ENT_W-1:0]   w_head;

   // A non-final stop edge is deliberately ignored so the open run merges
   // with the first pointers of the next tile.
   assign w_final_edge = cif.stop & ~stop_q & cif.last_tile;

   // Pointers are only consumed while an alignment is being collected.
   assign w_ptr_ok = cif.tb_valid && (cif.tb_pointer != 2'b00)
                     && ((state_q == c_IDLE) || (state_q == c_RUN));

   assign w_extend = run_valid_q && (cif.tb_pointer == cur_op_q)
                     && (len_q != c_LEN_MAX);

   assign w_empty = (wr_ptr_q == rd_ptr_q);
   assign w_full  = (wr_ptr_q[LOG_FIFO_DEPTH] != rd_ptr_q[LOG_FIFO_DEPTH])
                    && (wr_ptr_q[LOG_FIFO_DEPTH-1:0] == rd_ptr_q[LOG_FIFO_DEPTH-1:0]);
   assign w_pop   = ~w_empty & cif.op_ready;
   // A pop in the same cycle frees the slot being written, so a full FIFO
   // still accepts the push.
   assign w_push  = w_push_req & (~w_full | w_pop);
   assign w_head  = mem_q[rd_ptr_q[LOG_FIFO_DEPTH-1:0]];

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= c_IDLE;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         stop_q  <= cif.stop;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_IDLE: begin
            if (w_final_edge)  state_d = c_FLUSH;
            else if (w_ptr_ok) state_d = c_RUN;
         end
         c_RUN: begin
            if (w_final_edge) state_d = c_FLUSH;
         end
         c_FLUSH: state_d = c_DRAIN;
         c_DRAIN: begin
            if (w_pop && w_head[c_ENT_W-1]) state_d = c_IDLE;
         end
         default: state_d = c_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs (FIFO push request)
   // A run break and a flush never fall in the same cycle: the pointer that
   // arrives with the final stop edge is applied here, the flush follows in
   // FLUSH one cycle later.
   // ------------------------------------------------------------------------
   always_comb begin
      w_push_req  = 1'b0;
      w_push_data = '0;
      case (state_q)
         c_IDLE, c_RUN: begin
            if (w_ptr_ok && run_valid_q && !w_extend) begin
               w_push_req  = 1'b1;
               w_push_data = {1'b0, cur_op_q, len_q};
            end
         end
         c_FLUSH: begin
            w_push_req = 1'b1;
            if (run_valid_q) w_push_data = {1'b1, cur_op_q, len_q};
            else             w_push_data = {1'b1, 2'b00, {RUN_WIDTH{1'b0}}};
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------------
   // Run register
   // ------------------------------------------------------------------------
   always_comb begin
      run_valid_d = run_valid_q;
      cur_op_d    = cur_op_q;
      len_d       = len_q;
      if (w_ptr_ok) begin
         if (w_extend) begin
            len_d = len_q + RUN_WIDTH'(1);
         end else begin
            run_valid_d = 1'b1;
            cur_op_d    = cif.tb_pointer;
            len_d       = RUN_WIDTH'(1);
         end
      end
      if (state_q == c_FLUSH) begin
         run_valid_d = 1'b0;
         cur_op_d    = 2'b00;
         len_d       = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_valid_q <= 1'b0;
         cur_op_q    <= 2'b00;
         len_q       <= '0;
      end else begin
         run_valid_q <= run_valid_d;
         cur_op_q    <= cur_op_d;
         len_q       <= len_d;
      end
   end

   // ------------------------------------------------------------------------
   // Op FIFO
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (w_push)                wr_ptr_q   <= wr_ptr_q + c_PTR_W'(1);
         if (w_pop)                 rd_ptr_q   <= rd_ptr_q + c_PTR_W'(1);
         if (w_push_req && !w_push) overflow_q <= 1'b1;
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) mem_q[wr_ptr_q[LOG_FIFO_DEPTH-1:0]] <= w_push_data;
   end

   // Head fields are forced to zero while empty so the outputs are clean
   // straight out of reset.
   assign cif.op_valid = ~w_empty;
   assign cif.op_last  = w_empty ? 1'b0            : w_head[c_ENT_W-1];
   assign cif.op_code  = w_empty ? 2'b00           : w_head[RUN_WIDTH+1:RUN_WIDTH];
   assign cif.op_len   = w_empty ? {RUN_WIDTH{1'b0}} : w_head[RUN_WIDTH-1:0];
   assign cif.overflow = overflow_q;
   assign cif.busy     = (state_q != c_IDLE) | ~w_empty;

`ifdef TB_CIGAR_COUNT_EN
   // ------------------------------------------------------------------------
   // Per-type accepted pointer counters
   // ------------------------------------------------------------------------
   logic [31:0] m_total_q, i_total_q, d_total_q;
   logic        w_cnt_clr;

   assign w_cnt_clr = (state_q == c_DRAIN) && (state_d == c_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_total_q <= '0;
         i_total_q <= '0;
         d_total_q <= '0;
      end else if (w_cnt_clr) begin
         m_total_q <= '0;
         i_total_q <= '0;
         d_total_q <= '0;
      end else if (w_ptr_ok) begin
         if ((cif.tb_pointer == 2'd1) && (m_total_q != 32'hFFFF_FFFF)) m_total_q <= m_total_q + 32'd1;
         if ((cif.tb_pointer == 2'd2) && (i_total_q != 32'hFFFF_FFFF)) i_total_q <= i_total_q + 32'd1;
         if ((cif.tb_pointer == 2'd3) && (d_total_q != 32'hFFFF_FFFF)) d_total_q <= d_total_q + 32'd1;
      end
   end

   assign cif.m_total = m_total_q;
   assign cif.i_total = i_total_q;
   assign cif.d_total = d_total_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tb_cigar_rle.sv
// ============================================================================
// Module      : tb_tb_cigar_rle
// Description : Self-checking bench for tb_cigar_rle (RUN_WIDTH=4,
//               FIFO_DEPTH=16). Expected ops are queued as stimulus is
//               driven and compared as the encoder hands them out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tb_cigar_rle;

   localparam int RW = 4;
   typedef logic [RW+2:0] ent_t;  // {last, code, len}

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   tb_cigar_rle_if #(.RUN_WIDTH(RW)) cif ();

   tb_cigar_rle #(
      .RUN_WIDTH      (RW),
      .FIFO_DEPTH     (16),
      .LOG_FIFO_DEPTH (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .cif (cif)
   );

   int   n_total = 0;
   int   n_pass  = 0;
   ent_t exp_q[$];

   // ------------------------------------------------------------------------
   // Stimulus helpers (inputs change only on the falling edge)
   // ------------------------------------------------------------------------
   task automatic ptr(input logic [1:0] code);
      cif.tb_valid   = 1'b1;
      cif.tb_pointer = code;
      @(negedge clk);
      cif.tb_valid   = 1'b0;
      cif.tb_pointer = 2'b00;
   endtask

   task automatic final_stop();
      cif.stop      = 1'b1;
      cif.last_tile = 1'b1;
      @(negedge clk);
      cif.last_tile = 1'b0;
   endtask

   task automatic tile_stop();
      cif.stop      = 1'b1;
      cif.last_tile = 1'b0;
      @(negedge clk);
      @(negedge clk);
      cif.stop = 1'b0;
      @(negedge clk);
   endtask

   task automatic end_alignment();
      cif.stop = 1'b0;
      @(negedge clk);
   endtask

   // ------------------------------------------------------------------------
   // Tests
   // ------------------------------------------------------------------------
   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      n_total++; if (cif.op_valid !== 1'b0) $display("FAIL reset_op_valid: got %b expected 0", cif.op_valid); else n_pass++;
      n_total++; if (cif.op_code !== 2'b00) $display("FAIL reset_op_code: got %0d expected 0", cif.op_code); else n_pass++;
      n_total++; if (cif.op_len !== 4'd0) $display("FAIL reset_op_len: got %0d expected 0", cif.op_len); else n_pass++;
      n_total++; if (cif.op_last !== 1'b0) $display("FAIL reset_op_last: got %b expected 0", cif.op_last); else n_pass++;
      n_total++; if (cif.overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", cif.overflow); else n_pass++;
      n_total++; if (cif.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", cif.busy); else n_pass++;
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      ent_t got, want;
      ptr(2'd1); ptr(2'd1); ptr(2'd1);
      ptr(2'd2); exp_q.push_back({1'b0, 2'd1, 4'd3});
      ptr(2'd2);
      ptr(2'd3); exp_q.push_back({1'b0, 2'd2, 4'd2});
      final_stop(); exp_q.push_back({1'b1, 2'd3, 4'd1});
      cif.op_ready = 1'b1;
      for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
         if (cif.op_valid === 1'b1) begin
            got  = {cif.op_last, cif.op_code, cif.op_len};
            want = exp_q.pop_front();
            n_total++;
            if (got !== want) $display("FAIL basic_op: got %h expected %h", got, want); else n_pass++;
         end
         @(negedge clk);
      end
      n_total++;
      if (exp_q.size() != 0) begin
         $display("FAIL basic_timeout: got %0d ops missing expected 0", exp_q.size());
         exp_q.delete();
      end else n_pass++;
      n_total++; if (cif.busy !== 1'b0) $display("FAIL basic_busy_end: got %b expected 0", cif.busy); else n_pass++;
      n_total++; if (cif.op_valid !== 1'b0) $display("FAIL basic_extra_op: got %b expected 0", cif.op_valid); else n_pass++;
      cif.op_ready = 1'b0;
      end_alignment();
   endtask

   task automatic test_tile_merge();
      ent_t got, want;
      for (int k = 0; k < 5; k++) ptr(2'd1);
      tile_stop();
      n_total++; if (cif.op_valid !== 1'b0) $display("FAIL merge_no_op_at_tile: got %b expected 0", cif.op_valid); else n_pass++;
      for (int k = 0; k < 4; k++) ptr(2'd1);
      final_stop(); exp_q.push_back({1'b1, 2'd1, 4'd9});
      cif.op_ready = 1'b1;
      for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
         if (cif.op_valid === 1'b1) begin
            got  = {cif.op_last, cif.op_code, cif.op_len};
            want = exp_q.pop_front();
            n_total++;
            if (got !== want) $display("FAIL merge_op: got %h expected %h", got, want); else n_pass++;
         end
         @(negedge clk);
      end
      n_total++;
      if (exp_q.size() != 0) begin
         $display("FAIL merge_timeout: got %0d ops missing expected 0", exp_q.size());
         exp_q.delete();
      end else n_pass++;
      n_total++; if (cif.op_valid !== 1'b0) $display("FAIL merge_extra_op: got %b expected 0", cif.op_valid); else n_pass++;
      cif.op_ready = 1'b0;
      end_alignment();
   endtask

   task automatic test_saturation();
      ent_t got, want;
      for (int k = 0; k < 20; k++) begin
         ptr(2'd1);
         if (k == 15) exp_q.push_back({1'b0, 2'd1, 4'd15});
      end
      final_stop(); exp_q.push_back({1'b1, 2'd1, 4'd5});
      cif.op_ready = 1'b1;
      for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
         if (cif.op_valid === 1'b1) begin
            got  = {cif.op_last, cif.op_code, cif.op_len};
            want = exp_q.pop_front();
            n_total++;
            if (got !== want) $display("FAIL sat_op: got %h expected %h", got, want); else n_pass++;
         end
         @(negedge clk);
      end
      n_total++;
      if (exp_q.size() != 0) begin
         $display("FAIL sat_timeout: got %0d ops missing expected 0", exp_q.size());
         exp_q.delete();
      end else n_pass++;
      n_total++; if (cif.busy !== 1'b0) $display("FAIL sat_busy_end: got %b expected 0", cif.busy); else n_pass++;
      cif.op_ready = 1'b0;
      end_alignment();
   endtask

   task automatic test_empty_alignment();
      ent_t got, want;
      final_stop(); exp_q.push_back({1'b1, 2'd0, 4'd0});
      cif.op_ready = 1'b1;
      for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
         if (cif.op_valid === 1'b1) begin
            got  = {cif.op_last, cif.op_code, cif.op_len};
            want = exp_q.pop_front();
            n_total++;
            if (got !== want) $display("FAIL empty_op: got %h expected %h", got, want); else n_pass++;
         end
         @(negedge clk);
      end
      n_total++;
      if (exp_q.size() != 0) begin
         $display("FAIL empty_timeout: got %0d ops missing expected 0", exp_q.size());
         exp_q.delete();
      end else n_pass++;
      n_total++; if (cif.busy !== 1'b0) $display("FAIL empty_busy_end: got %b expected 0", cif.busy); else n_pass++;
      cif.op_ready = 1'b0;
      end_alignment();
   endtask

   task automatic test_ptr_with_stop();
      ent_t got, want;
      ptr(2'd1); ptr(2'd1);
      // Run-breaking pointer lands in the same cycle as the final stop edge.
      cif.tb_valid   = 1'b1;
      cif.tb_pointer = 2'd2;
      cif.stop       = 1'b1;
      cif.last_tile  = 1'b1;
      exp_q.push_back({1'b0, 2'd1, 4'd2});
      exp_q.push_back({1'b1, 2'd2, 4'd1});
      @(negedge clk);
      cif.tb_valid   = 1'b0;
      cif.tb_pointer = 2'b00;
      cif.last_tile  = 1'b0;
      cif.op_ready   = 1'b1;
      for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
         if (cif.op_valid === 1'b1) begin
            got  = {cif.op_last, cif.op_code, cif.op_len};
            want = exp_q.pop_front();
            n_total++;
            if (got !== want) $display("FAIL same_cycle_op: got %h expected %h", got, want); else n_pass++;
         end
         @(negedge clk);
      end
      n_total++;
      if (exp_q.size() != 0) begin
         $display("FAIL same_cycle_timeout: got %0d ops missing expected 0", exp_q.size());
         exp_q.delete();
      end else n_pass++;
      cif.op_ready = 1'b0;
      end_alignment();
   endtask

   task automatic test_overflow();
      ent_t       got, want;
      logic [1:0] code;
      for (int k = 0; k < 17; k++) begin
         code = (k % 2 == 0) ? 2'd1 : 2'd2;
         ptr(code);
         if (k >= 1) exp_q.push_back({1'b0, (code == 2'd1) ? 2'd2 : 2'd1, 4'd1});
      end
      n_total++; if (cif.overflow !== 1'b0) $display("FAIL ovf_exact_full: got %b expected 0", cif.overflow); else n_pass++;
      // The flushed final op finds the FIFO full and is dropped.
      final_stop();
      @(negedge clk);
      n_total++; if (cif.overflow !== 1'b1) $display("FAIL ovf_set: got %b expected 1", cif.overflow); else n_pass++;
      cif.op_ready = 1'b1;
      for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
         if (cif.op_valid === 1'b1) begin
            got  = {cif.op_last, cif.op_code, cif.op_len};
            want = exp_q.pop_front();
            n_total++;
            if (got !== want) $display("FAIL ovf_op: got %h expected %h", got, want); else n_pass++;
         end
         @(negedge clk);
      end
      n_total++;
      if (exp_q.size() != 0) begin
         $display("FAIL ovf_timeout: got %0d ops missing expected 0", exp_q.size());
         exp_q.delete();
      end else n_pass++;
      n_total++; if (cif.op_valid !== 1'b0) $display("FAIL ovf_drained: got %b expected 0", cif.op_valid); else n_pass++;
      n_total++; if (cif.overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", cif.overflow); else n_pass++;
      n_total++; if (cif.busy !== 1'b1) $display("FAIL ovf_busy_drain: got %b expected 1", cif.busy); else n_pass++;
      cif.op_ready = 1'b0;
      cif.stop     = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      ent_t got, want;
      ptr(2'd1); ptr(2'd2); ptr(2'd3); ptr(2'd1);
      n_total++; if (cif.op_valid !== 1'b1) $display("FAIL rstmid_queued: got %b expected 1", cif.op_valid); else n_pass++;
      #2 rst = 1'b0;
      #1;
      n_total++; if (cif.op_valid !== 1'b0) $display("FAIL rstmid_op_valid: got %b expected 0", cif.op_valid); else n_pass++;
      n_total++; if (cif.busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", cif.busy); else n_pass++;
      n_total++; if (cif.overflow !== 1'b0) $display("FAIL rstmid_overflow: got %b expected 0", cif.overflow); else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      ptr(2'd1); ptr(2'd1);
      final_stop(); exp_q.push_back({1'b1, 2'd1, 4'd2});
      cif.op_ready = 1'b1;
      for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
         if (cif.op_valid === 1'b1) begin
            got  = {cif.op_last, cif.op_code, cif.op_len};
            want = exp_q.pop_front();
            n_total++;
            if (got !== want) $display("FAIL rstmid_op: got %h expected %h", got, want); else n_pass++;
         end
         @(negedge clk);
      end
      n_total++;
      if (exp_q.size() != 0) begin
         $display("FAIL rstmid_timeout: got %0d ops missing expected 0", exp_q.size());
         exp_q.delete();
      end else n_pass++;
      n_total++; if (cif.op_valid !== 1'b0) $display("FAIL rstmid_extra_op: got %b expected 0", cif.op_valid); else n_pass++;
      n_total++; if (cif.busy !== 1'b0) $display("FAIL rstmid_busy_end: got %b expected 0", cif.busy); else n_pass++;
      cif.op_ready = 1'b0;
      end_alignment();
   endtask

   initial begin
      cif.tb_valid   = 1'b0;
      cif.tb_pointer = 2'b00;
      cif.stop       = 1'b0;
      cif.last_tile  = 1'b0;
      cif.op_ready   = 1'b0;
      test_reset();
      test_basic();
      test_tile_merge();
      test_saturation();
      test_empty_alignment();
      test_ptr_with_stop();
      test_overflow();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
